// File: rtl/program_loader.sv
// Byte-stream program/data loader sitting in front of the CPU top.
// Decodes framed commands, packs payload bytes little-endian into 32-bit
// instruction words or 64-bit data words, and drives the CPU's external
// memory write ports and enable line.
module program_loader #(
  parameter int unsigned IMEM_STRIDE = 4,
  parameter int unsigned DMEM_STRIDE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;

  logic [1:0]  r_state;
  logic        r_is_dmem;
  logic [1:0]  r_hdr_idx;
  logic [15:0] r_count;
  logic [15:0] r_base;
  logic [2:0]  r_byte_idx;
  logic [15:0] r_words;
  logic [63:0] r_asm;
  logic [63:0] r_addr_i;
  logic [31:0] r_wdata_i;
  logic [63:0] r_addr_d;
  logic [63:0] r_wdata_d;
  logic        r_cpu_en;
  logic        r_error;

  logic        w_accept;
  logic        w_last_byte;
  logic [63:0] w_asm_next;
  logic [16:0] w_index;
  logic [63:0] w_addr_i;
  logic [63:0] w_addr_d;
  logic [15:0] w_words_inc;

  assign w_accept    = in_valid && in_ready;
  assign w_last_byte = r_is_dmem ? (r_byte_idx == 3'd7) : (r_byte_idx == 3'd3);
  // 17-bit word index so BASE + i carries past 0xFFFF instead of wrapping
  assign w_index     = {1'b0, r_base} + {1'b0, r_words};
  assign w_addr_i    = {47'd0, w_index} * 64'(IMEM_STRIDE);
  assign w_addr_d    = {47'd0, w_index} * 64'(DMEM_STRIDE);
  assign w_words_inc = r_words + 16'd1;

  // Merge the incoming byte into its little-endian lane of the word being assembled
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_byte_idx, 3'b000} +: 8] = in_data;
  end

  // Frame decode FSM plus the registered write-port address/data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_dmem  <= 1'b0;
      r_hdr_idx  <= 2'd0;
      r_count    <= 16'd0;
      r_base     <= 16'd0;
      r_byte_idx <= 3'd0;
      r_words    <= 16'd0;
      r_asm      <= 64'd0;
      r_addr_i   <= 64'd0;
      r_wdata_i  <= 32'd0;
      r_addr_d   <= 64'd0;
      r_wdata_d  <= 64'd0;
      r_cpu_en   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (in_data)
              CMD_IMEM, CMD_DMEM: begin
                r_is_dmem <= (in_data == CMD_DMEM);
                r_cpu_en  <= 1'b0;
                r_hdr_idx <= 2'd0;
                r_state   <= S_HDR;
              end
              CMD_RUN:  r_cpu_en <= 1'b1;
              CMD_HALT: r_cpu_en <= 1'b0;
              default:  r_error  <= 1'b1;
            endcase
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_hdr_idx <= r_hdr_idx + 2'd1;
            case (r_hdr_idx)
              2'd0: r_count[7:0]  <= in_data;
              2'd1: r_count[15:8] <= in_data;
              2'd2: r_base[7:0]   <= in_data;
              default: begin
                r_base[15:8] <= in_data;
                r_byte_idx   <= 3'd0;
                r_words      <= 16'd0;
                r_state      <= (r_count != 16'd0) ? S_DATA : S_IDLE;
              end
            endcase
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm      <= w_asm_next;
            r_byte_idx <= r_byte_idx + 3'd1;
            if (w_last_byte) begin
              r_byte_idx <= 3'd0;
              r_state    <= S_WRITE;
              // Only the target port's address/data move; the other holds
              if (r_is_dmem) begin
                r_addr_d  <= w_addr_d;
                r_wdata_d <= w_asm_next;
              end else begin
                r_addr_i  <= w_addr_i;
                r_wdata_i <= w_asm_next[31:0];
              end
            end
          end
        end
        default: begin
          r_words <= w_words_inc;
          r_state <= (w_words_inc == r_count) ? S_IDLE : S_DATA;
        end
      endcase
    end
  end

  assign in_ready    = (r_state != S_WRITE);
  assign busy        = (r_state != S_IDLE);
  assign wen_ext     = (r_state == S_WRITE) && !r_is_dmem;
  assign wen_ext_2   = (r_state == S_WRITE) && r_is_dmem;
  assign addr_ext    = r_addr_i;
  assign wdata_ext   = r_wdata_i;
  assign addr_ext_2  = r_addr_d;
  assign wdata_ext_2 = r_wdata_d;
  assign cpu_enable  = r_cpu_en;
  assign error       = r_error;

endmodule
